pipelined_mult_unit: RTL and testbench



---
 rtl/mult_pkg.sv | 23 ++
 rtl/mult_pipe_stage.sv | 26 ++
 rtl/pipelined_mult_unit.sv | 135 +++++++++++++
 tb/tb_pipelined_mult_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the pipelined MIPS multiplier.
package mult_pkg;

    localparam int MULT_DATA_W     = 32;
    localparam int MULT_RD_W       = 5;
    localparam int MULT_STAGES_MIN = 1;
    localparam int MULT_STAGES_MAX = 8;

    // Field order matters: valid is the MSB when a slot is flattened to a vector.
    typedef struct packed {
        logic                   valid;
        logic [MULT_RD_W-1:0]   rd;
        logic [MULT_DATA_W-1:0] hi;
        logic [MULT_DATA_W-1:0] lo;
    } mult_slot_t;

    localparam int MULT_SLOT_W = $bits(mult_slot_t);

    function automatic bit stages_ok(input int stages);
        return (stages >= MULT_STAGES_MIN) && (stages <= MULT_STAGES_MAX);
    endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// One pipeline slot: synchronous reset, synchronous clear and hold-enable.
module mult_pipe_stage
    import mult_pkg::*;
#(
    parameter int W = MULT_SLOT_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    // Clear wins over enable so a flush lands even while the pipe is stalled.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_q <= '0;
        end else if (i_clr) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/pipelined_mult_unit.sv
// Fully pipelined signed/unsigned multiplier with stall/flush and a tagged full-width product.
// Optional HI/LO architectural registers are built when MULT_HILO_EN is defined.
module pipelined_mult_unit
    import mult_pkg::*;
#(
    parameter int DATA_W = MULT_DATA_W,
    parameter int STAGES = 4,
    parameter int RD_W   = MULT_RD_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic              i_signed,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [RD_W-1:0]   i_rd,
    input  logic              i_stall,
    input  logic              i_flush,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_result_hi,
    output logic [DATA_W-1:0] o_result_lo,
    output logic [RD_W-1:0]   o_rd,
    output logic              o_busy,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo
);

    localparam bit STAGES_LEGAL = stages_ok(STAGES);
    localparam int PROD_W       = 2 * DATA_W;

    generate
        if (!STAGES_LEGAL) begin : g_bad_stages
            $error("pipelined_mult_unit: STAGES must be within 1..8");
        end
    endgenerate

    // Same layout as mult_slot_t, sized by this instance's parameters.
    typedef struct packed {
        logic              valid;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } slot_t;

    localparam int SLOT_W    = $bits(slot_t);
    localparam int VALID_BIT = SLOT_W - 1;

    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] b_ext;
    logic [PROD_W-1:0] prod;
    slot_t             slot_in;

    // Extending to 2*DATA_W and truncating the product gives the exact result for both modes.
    always_comb begin
        a_ext = i_signed ? {{DATA_W{i_a[DATA_W-1]}}, i_a} : {{DATA_W{1'b0}}, i_a};
        b_ext = i_signed ? {{DATA_W{i_b[DATA_W-1]}}, i_b} : {{DATA_W{1'b0}}, i_b};
        prod  = a_ext * b_ext;
    end

    always_comb begin
        slot_in = '0;
        if (i_valid) begin
            slot_in.valid = 1'b1;
            slot_in.rd    = i_rd;
            slot_in.hi    = prod[PROD_W-1:DATA_W];
            slot_in.lo    = prod[DATA_W-1:0];
        end
    end

    logic              stage_en;
    logic [SLOT_W-1:0] slot_d [STAGES];
    logic [SLOT_W-1:0] slot_q [STAGES];

    assign stage_en = ~i_stall;

    // Accept gating (stall/flush) is implied by the stage enable and clear.
    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign slot_d[k] = slot_in;
            end else begin : g_link
                assign slot_d[k] = slot_q[k-1];
            end

            mult_pipe_stage #(
                .W (SLOT_W)
            ) u_stage (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_en    (stage_en),
                .i_clr   (i_flush),
                .i_d     (slot_d[k]),
                .o_q     (slot_q[k])
            );
        end
    endgenerate

    slot_t out_slot;
    assign out_slot = slot_q[STAGES-1];

    assign o_valid     = out_slot.valid;
    assign o_result_hi = out_slot.valid ? out_slot.hi : '0;
    assign o_result_lo = out_slot.valid ? out_slot.lo : '0;
    assign o_rd        = out_slot.valid ? out_slot.rd : '0;

    always_comb begin
        o_busy = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            o_busy = o_busy | slot_q[k][VALID_BIT];
        end
    end

`ifdef MULT_HILO_EN
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    // A stalled result is only written on the cycle it is finally consumed.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (o_valid && !i_stall) begin
            hi_q <= o_result_hi;
            lo_q <= o_result_lo;
        end
    end

    assign o_hi = hi_q;
    assign o_lo = lo_q;
`else
    assign o_hi = '0;
    assign o_lo = '0;
`endif

endmodule

// File: tb/tb_pipelined_mult_unit.sv
// Directed-vector bench for pipelined_mult_unit (STAGES=4 main instance, STAGES=1 boundary instance).
module tb_pipelined_mult_unit;

`ifdef MULT_HILO_EN
    localparam bit HILO = 1'b1;
`else
    localparam bit HILO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        stall;
    logic        flush;

    logic        o_valid, o_busy;
    logic [31:0] o_result_hi, o_result_lo, o_hi, o_lo;
    logic [4:0]  o_rd;

    logic        s1_valid, s1_busy;
    logic [31:0] s1_result_hi, s1_result_lo, s1_hi, s1_lo;
    logic [4:0]  s1_rd;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipelined_mult_unit #(.DATA_W(32), .STAGES(4), .RD_W(5)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_signed(sgn),
        .i_a(a), .i_b(b), .i_rd(rd), .i_stall(stall), .i_flush(flush),
        .o_valid(o_valid), .o_result_hi(o_result_hi), .o_result_lo(o_result_lo),
        .o_rd(o_rd), .o_busy(o_busy), .o_hi(o_hi), .o_lo(o_lo)
    );

    pipelined_mult_unit #(.DATA_W(32), .STAGES(1), .RD_W(5)) dut_s1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_signed(sgn),
        .i_a(a), .i_b(b), .i_rd(rd), .i_stall(stall), .i_flush(flush),
        .o_valid(s1_valid), .o_result_hi(s1_result_hi), .o_result_lo(s1_result_lo),
        .o_rd(s1_rd), .o_busy(s1_busy), .o_hi(s1_hi), .o_lo(s1_lo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] hl(input logic [31:0] v);
        return HILO ? v : 32'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [31:0] x,
                         input logic [31:0] y, input logic [4:0] r);
        valid = v;
        sgn   = s;
        a     = x;
        b     = y;
        rd    = r;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] h,
                           input logic [31:0] l, input logic [4:0] r);
        chk({tag, ".valid"}, 64'(o_valid), 64'(v));
        chk({tag, ".hi"},    64'(o_result_hi), 64'(h));
        chk({tag, ".lo"},    64'(o_result_lo), 64'(l));
        chk({tag, ".rd"},    64'(o_rd), 64'(r));
    endtask

    task automatic chk_hilo(input string tag, input logic [31:0] h, input logic [31:0] l);
        chk({tag, ".HI"}, 64'(o_hi), 64'(hl(h)));
        chk({tag, ".LO"}, 64'(o_lo), 64'(hl(l)));
    endtask

    // Back-to-back vectors: 3*5, 0x100*0x100, 0x80000000*4 (unsigned), -2^31 * -1 (signed)
    logic [31:0] v_a  [4] = '{32'd3, 32'h100, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] v_b  [4] = '{32'd5, 32'h100, 32'd4, 32'hFFFF_FFFF};
    logic        v_s  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] v_hi [4] = '{32'h0, 32'h0, 32'h2, 32'h0};
    logic [31:0] v_lo [4] = '{32'd15, 32'h1_0000, 32'h0, 32'h8000_0000};

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;

        chk_out("rst", 1'b0, 32'h0, 32'h0, 5'd0);
        chk("rst.busy", 64'(o_busy), 64'(0));
        chk_hilo("rst", 32'h0, 32'h0);
        chk("rst.s1_valid", 64'(s1_valid), 64'(0));

        // Scenario 1: unsigned 0xFFFFFFFF * 2, rd 9
        drive(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2, 5'd9);
        tick();
        idle();
        chk("s1.st1_valid", 64'(s1_valid), 64'(1));
        chk("s1.st1_hi", 64'(s1_result_hi), 64'(32'h1));
        chk("s1.st1_lo", 64'(s1_result_lo), 64'(32'hFFFF_FFFE));
        chk("s1.st1_rd", 64'(s1_rd), 64'(9));
        chk("s1.st1_busy", 64'(s1_busy), 64'(1));
        for (int c = 1; c <= 3; c++) begin
            chk("s1.wait_valid", 64'(o_valid), 64'(0));
            chk("s1.wait_busy", 64'(o_busy), 64'(1));
            if (c == 2) begin
                chk("s1.st1_after", 64'(s1_valid), 64'(0));
                chk("s1.st1_HI", 64'(s1_hi), 64'(hl(32'h1)));
                chk("s1.st1_LO", 64'(s1_lo), 64'(hl(32'hFFFF_FFFE)));
            end
            tick();
        end
        chk_out("s1.c4", 1'b1, 32'h1, 32'hFFFF_FFFE, 5'd9);
        chk_hilo("s1.c4", 32'h0, 32'h0);
        tick();
        chk_out("s1.c5", 1'b0, 32'h0, 32'h0, 5'd0);
        chk("s1.c5_busy", 64'(o_busy), 64'(0));
        chk_hilo("s1.c5", 32'h1, 32'hFFFF_FFFE);

        // Scenario 2: -3*7 signed then the same operands unsigned
        drive(1'b1, 1'b1, 32'hFFFF_FFFD, 32'd7, 5'd3);
        tick();
        drive(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd7, 5'd4);
        tick();
        idle();
        tick();
        tick();
        chk_out("s2.signed", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5'd3);
        tick();
        chk_out("s2.unsigned", 1'b1, 32'h6, 32'hFFFF_FFEB, 5'd4);
        chk_hilo("s2.c5", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        tick();
        chk_out("s2.c6", 1'b0, 32'h0, 32'h0, 5'd0);
        chk_hilo("s2.c6", 32'h6, 32'hFFFF_FFEB);

        // Scenario 3: four back-to-back issues, stall in cycles 5-6 with junk issue presented
        for (int c = 0; c <= 12; c++) begin
            int op;
            int hop;
            op  = (c == 4) ? 0 : (c >= 5 && c <= 7) ? 1 : (c == 8) ? 2 : (c == 9) ? 3 : -1;
            hop = (c <= 4) ? -1 : (c <= 7) ? 0 : (c == 8) ? 1 : (c == 9) ? 2 : 3;
            if (op >= 0)
                chk_out("s3.res", 1'b1, v_hi[op], v_lo[op], 5'(op + 1));
            else
                chk_out("s3.idle", 1'b0, 32'h0, 32'h0, 5'd0);
            if (hop >= 0)
                chk_hilo("s3.hilo", v_hi[hop], v_lo[hop]);
            else
                chk_hilo("s3.hilo_prev", 32'h6, 32'hFFFF_FFEB);
            if (c < 4) begin
                stall = 1'b0;
                drive(1'b1, v_s[c], v_a[c], v_b[c], 5'(c + 1));
            end else if (c == 5 || c == 6) begin
                stall = 1'b1;
                drive(1'b1, 1'b0, 32'd1, 32'd1, 5'd31);
            end else begin
                stall = 1'b0;
                idle();
            end
            tick();
        end
        chk("s3.busy_end", 64'(o_busy), 64'(0));

        // Scenario 4: three ops in flight, flush with a coincident issue
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 32'd2, 32'd3, 5'(c + 10));
            tick();
        end
        chk("s4.busy_pre", 64'(o_busy), 64'(1));
        drive(1'b1, 1'b0, 32'd5, 32'd5, 5'd20);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        chk("s4.busy_post", 64'(o_busy), 64'(0));
        for (int c = 4; c <= 8; c++) begin
            chk("s4.no_valid", 64'(o_valid), 64'(0));
            tick();
        end
        chk_hilo("s4.hilo", 32'h0, 32'h8000_0000);

        // Scenario 5: reset with stall asserted while two ops are in flight
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 1'b0, 32'd7, 32'd7, 5'(c + 1));
            tick();
        end
        idle();
        chk_hilo("s5.pre", 32'h0, 32'h8000_0000);
        rst_n = 1'b0;
        stall = 1'b1;
        tick();
        rst_n = 1'b1;
        stall = 1'b0;
        chk_out("s5.post", 1'b0, 32'h0, 32'h0, 5'd0);
        chk("s5.busy", 64'(o_busy), 64'(0));
        chk_hilo("s5.post", 32'h0, 32'h0);
        for (int c = 3; c <= 8; c++) begin
            chk("s5.no_valid", 64'(o_valid), 64'(0));
            tick();
        end
        chk_hilo("s5.end", 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
